adc_trigger_responder: RTL and testbench

- ADC-side end of the transmit-trigger handshake.
- Samples the transmit controller's trigger line into the ADC clock domain and returns an acknowledge.
- On a trigger, captures a programmed number of ADC samples into a record buffer via a simple write port.
- Sits between the transmit output controller (trigger/ack) and the sample RAM feeding the host readout.

---
 rtl/adc_trigger_responder_if.sv | 36 +++
 rtl/adc_trigger_responder.sv | 143 ++++++++++++++
 tb/tb_adc_trigger_responder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_trigger_responder_if.sv
// Bus bundle between the ADC trigger responder and its surroundings:
// the trigger/ack handshake with the transmit controller, the ADC sample
// stream, the record-buffer write port and the status outputs.
// The "slave" modport is the responder itself; "master" is the environment.
interface adc_trigger_responder_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 13
);
  // Control and sample inputs to the responder
  logic              iArm;
  logic              itxADCTriggerLine;
  logic [ADDR_W:0]   iRecLength;
  logic [DATA_W-1:0] iADCData;
  logic              iADCDataValid;

  // Handshake, write port and status outputs of the responder
  logic              otxADCTriggerAck;
  logic              oWrEn;
  logic [ADDR_W-1:0] oWrAddr;
  logic [DATA_W-1:0] oWrData;
  logic              oCapturing;
  logic              oDone;
  logic [ADDR_W:0]   oSampleCount;

  modport slave (
    input  iArm, itxADCTriggerLine, iRecLength, iADCData, iADCDataValid,
    output otxADCTriggerAck, oWrEn, oWrAddr, oWrData, oCapturing, oDone,
           oSampleCount
  );

  modport master (
    output iArm, itxADCTriggerLine, iRecLength, iADCData, iADCDataValid,
    input  otxADCTriggerAck, oWrEn, oWrAddr, oWrData, oCapturing, oDone,
           oSampleCount
  );
endinterface

// File: rtl/adc_trigger_responder.sv
// ADC-side end of the transmit-trigger handshake. The asynchronous trigger
// line is synchronized into adcCLK, a rising edge while armed is
// acknowledged and starts capture of a programmed number of samples into a
// record buffer through a registered write port.
module adc_trigger_responder #(
  parameter int DATA_W      = 12,
  parameter int ADDR_W      = 13,
  parameter int SYNC_STAGES = 2   // must be at least 2
) (
  input  logic                     adcCLK,
  input  logic                     iRESET,
  adc_trigger_responder_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Largest record the buffer can hold; longer requests are clamped to it.
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  state_t                  state_q;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    trig_d_q;
  logic [ADDR_W:0]         count_q;
  logic [ADDR_W:0]         len_q;
  logic                    ack_q;
  logic                    wr_en_q;
  logic [ADDR_W-1:0]       wr_addr_q;
  logic [DATA_W-1:0]       wr_data_q;
  logic                    capturing_q;
  logic                    done_q;

  logic                    trig_s;
  logic                    trig_rise;
  logic [ADDR_W:0]         len_d;

  assign trig_s    = sync_q[SYNC_STAGES-1];
  assign trig_rise = trig_s & ~trig_d_q;
  assign len_d     = (bus.iRecLength > MAX_LEN) ? MAX_LEN : bus.iRecLength;

  // Trigger-line synchronizer chain plus the delayed copy for edge detection
  always_ff @(posedge adcCLK or posedge iRESET) begin
    if (iRESET) begin
      sync_q   <= '0;
      trig_d_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.itxADCTriggerLine};
      trig_d_q <= trig_s;
    end
  end

  // Capture FSM, sample counter, write port and ack handshake
  always_ff @(posedge adcCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      len_q       <= '0;
      ack_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      capturing_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // The write strobe is a single-cycle pulse unless a sample is taken.
      wr_en_q <= 1'b0;

      // Ack drops once the synchronized trigger is seen low, in any state.
      if (ack_q && !trig_s) begin
        ack_q <= 1'b0;
      end

      if (!bus.iArm) begin
        // Disarm wins over everything, including a rise or a final sample.
        state_q     <= S_IDLE;
        count_q     <= '0;
        ack_q       <= 1'b0;
        capturing_q <= 1'b0;
        done_q      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            count_q <= '0;
            state_q <= S_ARMED;
          end

          S_ARMED: begin
            if (trig_rise) begin
              ack_q   <= 1'b1;
              len_q   <= len_d;
              count_q <= '0;
              if (len_d == '0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q     <= S_CAPTURE;
                capturing_q <= 1'b1;
              end
            end
          end

          S_CAPTURE: begin
            // Once the last sample has been written the count equals the
            // latched length; no write is ever issued at count >= len.
            if (count_q >= len_q) begin
              state_q     <= S_DONE;
              capturing_q <= 1'b0;
              done_q      <= 1'b1;
            end else if (bus.iADCDataValid) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= count_q[ADDR_W-1:0];
              wr_data_q <= bus.iADCData;
              count_q   <= count_q + ONE;
            end
          end

          S_DONE: begin
            // Hold the result; further triggers are ignored until disarm.
            done_q <= 1'b1;
          end

          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.otxADCTriggerAck = ack_q;
  assign bus.oWrEn            = wr_en_q;
  assign bus.oWrAddr          = wr_addr_q;
  assign bus.oWrData          = wr_data_q;
  assign bus.oCapturing       = capturing_q;
  assign bus.oDone            = done_q;
  assign bus.oSampleCount     = count_q;

endmodule

// File: tb/tb_adc_trigger_responder.sv
// Directed-plus-random bench for adc_trigger_responder. The reference model
// treats a record as "the first len valid samples presented after the ack
// appears, written to addresses 0..len-1", with len clamped to the buffer.
module tb_adc_trigger_responder;
  localparam int DATA_W      = 12;
  localparam int ADDR_W      = 13;
  localparam int SYNC_STAGES = 2;
  localparam int MAXL        = 1 << ADDR_W;

  logic adcCLK = 1'b0;
  logic iRESET;

  adc_trigger_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  adc_trigger_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .adcCLK(adcCLK),
    .iRESET(iRESET),
    .bus(bus)
  );

  always #5 adcCLK = ~adcCLK;

  int n_assert = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] wa[$];
  logic [DATA_W-1:0] wd[$];
  logic [DATA_W-1:0] pres[$];

  // Write-port monitor
  always @(negedge adcCLK) begin
    if (bus.oWrEn === 1'b1) begin
      wa.push_back(bus.oWrAddr);
      wd.push_back(bus.oWrData);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " ack"},       bus.otxADCTriggerAck, 0);
    chk({tag, " wren"},      bus.oWrEn, 0);
    chk({tag, " capturing"}, bus.oCapturing, 0);
    chk({tag, " done"},      bus.oDone, 0);
    chk({tag, " count"},     bus.oSampleCount, 0);
  endtask

  task automatic rearm();
    bus.iArm = 1'b0;
    @(negedge adcCLK);
    bus.iArm = 1'b1;
    @(negedge adcCLK);
  endtask

  // Raise the trigger and wait (bounded) for the ack; returns the latency.
  task automatic trigger_and_wait_ack(output int lat);
    bus.itxADCTriggerLine = 1'b1;
    lat = 0;
    while (bus.otxADCTriggerAck !== 1'b1 && lat < 20) begin
      @(negedge adcCLK);
      lat++;
    end
  endtask

  // One full record: vmode 0 = valid every cycle with data 0x101+k,
  // 1 = random valid/data, 2 = valid pattern 1,0,0,1,0,1 with random data.
  task automatic do_record(input string tag, input int len_req, input int vmode, input int limit);
    int elen, lat, cyc, ack_fall, k, nchk;
    bit done_seen, v;
    int pat[6] = '{1, 0, 0, 1, 0, 1};
    logic [DATA_W-1:0] d;
    elen = (len_req > MAXL) ? MAXL : len_req;
    pres.delete(); wa.delete(); wd.delete();
    bus.iRecLength    = len_req[ADDR_W:0];
    bus.iADCDataValid = 1'b0;
    trigger_and_wait_ack(lat);
    chk({tag, " ack latency"}, lat, SYNC_STAGES + 1);
    bus.itxADCTriggerLine = 1'b0;
    cyc = 0; ack_fall = -1; done_seen = 0; k = 0;
    while (!(done_seen && ack_fall >= 0) && cyc < limit) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = 1'($urandom_range(0, 1));
        default: v = 1'(pat[cyc % 6]);
      endcase
      d = (vmode == 0) ? DATA_W'(32'h101 + k) : DATA_W'($urandom);
      bus.iADCDataValid = v;
      bus.iADCData      = d;
      if (v) begin
        pres.push_back(d);
        k++;
      end
      @(negedge adcCLK);
      cyc++;
      if (ack_fall < 0 && bus.otxADCTriggerAck === 1'b0) ack_fall = cyc;
      if (bus.oDone === 1'b1) done_seen = 1;
    end
    // Keep offering samples after completion: none may be written.
    bus.iADCDataValid = 1'b1;
    repeat (3) @(negedge adcCLK);
    bus.iADCDataValid = 1'b0;
    @(negedge adcCLK);
    chk({tag, " done reached"}, done_seen, 1);
    chk({tag, " ack fall"}, ack_fall, SYNC_STAGES + 1);
    chk({tag, " write count"}, wa.size(), elen);
    nchk = (wa.size() < elen) ? wa.size() : elen;
    for (int i = 0; i < nchk; i++) begin
      chk({tag, " addr"}, wa[i], i);
      chk({tag, " data"}, wd[i], pres[i]);
    end
    chk({tag, " oDone"}, bus.oDone, 1);
    chk({tag, " oSampleCount"}, bus.oSampleCount, elen);
    chk({tag, " oCapturing"}, bus.oCapturing, 0);
    chk({tag, " oWrEn"}, bus.oWrEn, 0);
    $display("record %s: len_req=%0d writes=%0d", tag, len_req, wa.size());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, cyc;
    iRESET = 1'b1;
    bus.iArm = 1'b0;
    bus.itxADCTriggerLine = 1'b0;
    bus.iRecLength = '0;
    bus.iADCData = '0;
    bus.iADCDataValid = 1'b0;
    repeat (3) @(negedge adcCLK);
    chk_idle_outputs("reset");
    chk("reset wraddr", bus.oWrAddr, 0);
    chk("reset wrdata", bus.oWrData, 0);
    iRESET = 1'b0;
    @(negedge adcCLK);

    // Basic record
    rearm();
    do_record("basic", 4, 0, 100);

    // Gapped valid, then a trigger in DONE must be ignored
    rearm();
    do_record("gapped", 3, 2, 100);
    bus.itxADCTriggerLine = 1'b1;
    repeat (6) @(negedge adcCLK);
    chk("done-retrig ack", bus.otxADCTriggerAck, 0);
    chk("done-retrig done", bus.oDone, 1);
    chk("done-retrig count", bus.oSampleCount, 3);
    bus.itxADCTriggerLine = 1'b0;
    repeat (4) @(negedge adcCLK);

    // Random records
    for (int r = 0; r < 4; r++) begin
      rearm();
      do_record("random", $urandom_range(1, 24), 1, 400);
    end

    // Zero length
    rearm();
    do_record("zero", 0, 1, 50);

    // Trigger already high when arming: no ack until it falls and rises
    bus.iArm = 1'b0;
    bus.itxADCTriggerLine = 1'b1;
    repeat (4) @(negedge adcCLK);
    bus.iArm = 1'b1;
    repeat (6) @(negedge adcCLK);
    chk("early ack", bus.otxADCTriggerAck, 0);
    chk("early capturing", bus.oCapturing, 0);
    bus.itxADCTriggerLine = 1'b0;
    repeat (4) @(negedge adcCLK);
    do_record("early-retrig", 5, 1, 200);

    // Abort after 2 of 8 samples
    rearm();
    bus.iRecLength = 9'(8);
    trigger_and_wait_ack(lat);
    chk("abort ack latency", lat, SYNC_STAGES + 1);
    bus.iADCDataValid = 1'b1;
    n = 0; cyc = 0;
    while (n < 2 && cyc < 20) begin
      @(negedge adcCLK);
      cyc++;
      if (bus.oWrEn === 1'b1) n++;
    end
    chk("abort writes seen", n, 2);
    chk("abort ack held", bus.otxADCTriggerAck, 1);
    bus.iArm = 1'b0;
    @(negedge adcCLK);
    chk_idle_outputs("abort");
    bus.itxADCTriggerLine = 1'b0;
    bus.iADCDataValid = 1'b0;
    repeat (4) @(negedge adcCLK);

    // Reset mid-capture
    rearm();
    bus.iRecLength = 9'(8);
    trigger_and_wait_ack(lat);
    bus.iADCDataValid = 1'b1;
    n = 0; cyc = 0;
    while (n < 3 && cyc < 20) begin
      @(negedge adcCLK);
      cyc++;
      if (bus.oWrEn === 1'b1) n++;
    end
    chk("midreset writes seen", n, 3);
    #2 iRESET = 1'b1;
    #1;
    chk_idle_outputs("midreset");
    chk("midreset wraddr", bus.oWrAddr, 0);
    chk("midreset wrdata", bus.oWrData, 0);
    bus.itxADCTriggerLine = 1'b0;
    bus.iADCDataValid = 1'b0;
    @(negedge adcCLK);
    iRESET = 1'b0;
    repeat (4) @(negedge adcCLK);
    do_record("post-reset", 5, 1, 200);

    // Full-size record, request clamped to buffer size
    rearm();
    do_record("full", MAXL + 5, 0, MAXL + 200);
    if (wa.size() > 0) chk("full last addr", wa[wa.size()-1], MAXL - 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
